// File: rtl/fpmult_radix_sat_if.sv
// Operand/result handshake bundle for the fixed-point radix multiplier.
interface fpmult_radix_sat_if #(
  parameter int unsigned N = 32
) ();
  logic         recv_val;
  logic         recv_rdy;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         send_val;
  logic         send_rdy;
  logic [N-1:0] c;
  logic         ovf;

  // Producer/consumer side: supplies operands, accepts results.
  modport master (
    output recv_val, a, b, send_rdy,
    input  recv_rdy, send_val, c, ovf
  );

  // Multiplier side.
  modport slave (
    input  recv_val, a, b, send_rdy,
    output recv_rdy, send_val, c, ovf
  );
endinterface

// File: rtl/fpmult_radix_sat.sv
// Iterative fixed-point multiplier: retires K multiplier bits per cycle, then
// rounds, shifts by D and saturates (or wraps) the 2N-bit product to N bits.
module fpmult_radix_sat #(
  parameter int unsigned N    = 32,
  parameter int unsigned D    = 16,
  parameter int unsigned SIGN = 1,
  parameter int unsigned K    = 2,
  parameter int unsigned SAT  = 1,
  parameter int unsigned RND  = 0
) (
  input logic               clk,
  input logic               reset,
  fpmult_radix_sat_if.slave bus
);

  localparam int unsigned Iters = N / K;
  localparam int unsigned CntW  = (Iters > 1) ? $clog2(Iters) : 1;
  localparam int unsigned W     = 2 * N;
  localparam int unsigned RndPos = (D > 0) ? D - 1 : 0;

  localparam logic [CntW-1:0] CntLast = CntW'(Iters - 1);
  localparam logic [W-1:0]    RndAdd  = (RND != 0 && D > 0) ? (W'(1) << RndPos) : '0;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  if (N % K != 0) begin : g_bad_radix
    $error("fpmult_radix_sat: N must be a multiple of K");
  end

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;     // multiplicand, pre-extended and shifted to digit weight
  logic [N-1:0]    b_q, b_d;     // remaining multiplier digits, LSB first
  logic [W-1:0]    acc_q, acc_d;
  logic [N-1:0]    c_q, c_d;
  logic            ovf_q, ovf_d;

  logic [W-1:0]    pp;
  logic [W-1:0]    rnd;
  logic [W-1:0]    shf;
  logic [N-1:0]    sat_val;
  logic            ovf_n;

  // Next-state, datapath step and final round/shift/saturate.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    c_d     = c_q;
    ovf_d   = ovf_q;
    pp      = '0;
    rnd     = '0;
    shf     = '0;
    sat_val = '0;
    ovf_n   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.recv_val) begin
          a_d     = (SIGN != 0) ? {{N{bus.a[N-1]}}, bus.a} : {{N{1'b0}}, bus.a};
          b_d     = bus.b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        for (int unsigned j = 0; j < K; j++) begin
          if (b_q[j]) begin
            // The multiplier MSB carries negative weight in two's complement.
            if (SIGN != 0 && j == K - 1 && cnt_q == CntLast) pp = pp - (a_q << j);
            else                                              pp = pp + (a_q << j);
          end
        end
        acc_d = acc_q + pp;
        a_d   = a_q << K;
        b_d   = b_q >> K;
        cnt_d = cnt_q + CntW'(1);

        if (cnt_q == CntLast) begin
          state_d = DONE;
          cnt_d   = '0;
          // Product fits in W bits even after the rounding increment.
          rnd = acc_d + RndAdd;
          if (SIGN != 0) begin
            shf     = $signed(rnd) >>> D;
            ovf_n   = ~(&shf[W-1:N-1]) & (|shf[W-1:N-1]);
            sat_val = shf[W-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
          end else begin
            shf     = rnd >> D;
            ovf_n   = |shf[W-1:N];
            sat_val = '1;
          end
          c_d   = (ovf_n && SAT != 0) ? sat_val : shf[N-1:0];
          ovf_d = ovf_n;
        end
      end

      DONE: begin
        if (bus.send_rdy) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.recv_rdy = (state_q == IDLE);
  assign bus.send_val = (state_q == DONE);
  assign bus.c        = c_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_fpmult_radix_sat.sv
// Bench for fpmult_radix_sat: directed vectors, handshake corner sequences and
// a random sweep over several parameterisations against an arithmetic model.
module tb_fpmult_radix_sat;

  localparam int NCFG = 7;
  // Config: 0 default, 1 wrap, 2 round, 3 K=1, 4 K=4, 5 K=32, 6 unsigned.
  localparam int unsigned CK   [NCFG] = '{2, 2, 2, 1, 4, 32, 2};
  localparam int unsigned CS   [NCFG] = '{1, 1, 1, 1, 1, 1, 0};
  localparam int unsigned CSAT [NCFG] = '{1, 0, 1, 1, 1, 1, 1};
  localparam int unsigned CR   [NCFG] = '{0, 0, 1, 0, 0, 0, 0};

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [NCFG-1:0] rv = '0;
  logic [NCFG-1:0] sr = '0;
  logic [31:0]     av [NCFG];
  logic [31:0]     bv [NCFG];
  logic [NCFG-1:0] rr;
  logic [NCFG-1:0] sv;
  logic [NCFG-1:0] ov;
  logic [31:0]     cv [NCFG];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    fpmult_radix_sat_if #(.N(32)) bus ();
    assign bus.recv_val = rv[g];
    assign bus.a        = av[g];
    assign bus.b        = bv[g];
    assign bus.send_rdy = sr[g];
    assign rr[g]        = bus.recv_rdy;
    assign sv[g]        = bus.send_val;
    assign cv[g]        = bus.c;
    assign ov[g]        = bus.ovf;

    fpmult_radix_sat #(
      .N(32), .D(16), .SIGN(CS[g]), .K(CK[g]), .SAT(CSAT[g]), .RND(CR[g])
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );
  end

  typedef struct {
    int          g;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        ovf;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end
  endtask

  // Exact product in wide signed arithmetic, then the rounding/overflow rules.
  function automatic void model(input int g, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] c, output logic ovf);
    logic signed [66:0] ea, eb, p, s;
    ea = (CS[g] != 0) ? {{35{a[31]}}, a} : {35'b0, a};
    eb = (CS[g] != 0) ? {{35{b[31]}}, b} : {35'b0, b};
    p  = ea * eb;
    if (CR[g] != 0) p = p + 67'sd32768;
    s = p >>> 16;
    if (CS[g] != 0) ovf = (s > 67'sd2147483647) || (s < -67'sd2147483648);
    else            ovf = (s > 67'sd4294967295);
    if (ovf && CSAT[g] != 0) begin
      if (CS[g] != 0) c = (s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else            c = 32'hFFFF_FFFF;
    end else begin
      c = s[31:0];
    end
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] r;
    logic [31:0] corners [4];
    corners = '{32'h0, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
    r = $urandom;
    case ($urandom_range(0, 4))
      0:       return r;
      1:       return {{12{r[19]}}, r[19:0]};
      2:       return {16'h0, r[15:0]};
      3:       return corners[$urandom_range(0, 3)];
      default: return r >> 8;
    endcase
  endfunction

  // One full transaction: accept, latency, result, optional stall and stray recv_val.
  task automatic run_op(input int g, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ec, input logic eo, input int stall,
                        input bit poke, input string name);
    int cyc;
    cyc = 0;
    while (!rr[g] && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    chk({name, " recv_rdy"}, 64'(rr[g]), 64'd1);
    rv[g] = 1'b1; av[g] = a; bv[g] = b; sr[g] = 1'b0;
    @(posedge clk); #1;
    rv[g] = 1'b0; av[g] = $urandom; bv[g] = $urandom;
    cyc = 0;
    while (!sv[g] && cyc < 200) begin
      if (poke && cyc == 2) begin
        rv[g] = 1'b1; av[g] = 32'h1234_5678; bv[g] = 32'h0005_0000;
      end else begin
        rv[g] = 1'b0;
      end
      @(posedge clk); #1; cyc++;
    end
    rv[g] = 1'b0;
    chk({name, " latency"}, 64'(cyc), 64'(32 / CK[g]));
    chk({name, " c"}, 64'(cv[g]), 64'(ec));
    chk({name, " ovf"}, 64'(ov[g]), 64'(eo));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({name, " stall {send_val,recv_rdy,ovf,c}"}, {29'd0, sv[g], rr[g], ov[g], cv[g]},
          {29'd0, 1'b1, 1'b0, eo, ec});
    end
    sr[g] = 1'b1;
    @(posedge clk); #1;
    sr[g] = 1'b0;
    chk({name, " after handshake {recv_rdy,send_val}"}, {62'd0, rr[g], sv[g]}, 64'b10);
  endtask

  initial begin
    logic [31:0] ra, rb, ec;
    logic        eo;
    int          seen;

    for (int g = 0; g < NCFG; g++) begin
      av[g] = '0;
      bv[g] = '0;
    end

    vt[0]  = '{0, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 1'b0};
    vt[1]  = '{0, 32'hFFFF_8000, 32'h0004_0000, 32'hFFFE_0000, 1'b0};
    vt[2]  = '{0, 32'h7FFF_0000, 32'h0002_0000, 32'h7FFF_FFFF, 1'b1};
    vt[3]  = '{1, 32'h7FFF_0000, 32'h0002_0000, 32'hFFFE_0000, 1'b1};
    vt[4]  = '{0, 32'h0000_0001, 32'h0000_8000, 32'h0000_0000, 1'b0};
    vt[5]  = '{2, 32'h0000_0001, 32'h0000_8000, 32'h0000_0001, 1'b0};
    vt[6]  = '{0, 32'h0000_0000, 32'h7FFF_0000, 32'h0000_0000, 1'b0};
    vt[7]  = '{0, 32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1};
    vt[8]  = '{6, 32'hFFFF_0000, 32'h0002_0000, 32'hFFFF_FFFF, 1'b1};
    vt[9]  = '{0, 32'h8000_0000, 32'h0002_0000, 32'h8000_0000, 1'b1};
    vt[10] = '{3, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 1'b0};
    vt[11] = '{5, 32'hFFFF_8000, 32'h0004_0000, 32'hFFFE_0000, 1'b0};

    // Outputs while reset is held.
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NCFG; g++) begin
      chk($sformatf("reset cfg%0d {recv_rdy,send_val,ovf,c}", g),
          {29'd0, rr[g], sv[g], ov[g], cv[g]}, {29'd0, 1'b1, 1'b0, 1'b0, 32'h0});
    end
    reset = 1'b0;

    foreach (vt[i]) begin
      run_op(vt[i].g, vt[i].a, vt[i].b, vt[i].c, vt[i].ovf, 0, 1'b0, $sformatf("vec%0d", i));
    end

    // Backpressure for 5 cycles with a stray operand pulse mid-calculation.
    run_op(0, 32'h0001_8000, 32'h0002_0000, 32'h0003_0000, 1'b0, 5, 1'b1, "stall_poke");

    // Reset during CALC at cycle t+5 aborts the operation.
    rv[0] = 1'b1; av[0] = 32'h0003_0000; bv[0] = 32'h0003_0000;
    @(posedge clk); #1;
    rv[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort {recv_rdy,send_val}", {62'd0, rr[0], sv[0]}, 64'b10);
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (sv[0]) seen++;
    end
    chk("abort no send_val", 64'(seen), 64'd0);
    run_op(0, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b0, 0, 1'b0, "post_abort");

    // Random sweep across all configurations.
    for (int g = 0; g < NCFG; g++) begin
      for (int n = 0; n < 10; n++) begin
        ra = pick();
        rb = pick();
        model(g, ra, rb, ec, eo);
        run_op(g, ra, rb, ec, eo, n % 3, 1'b0,
               $sformatf("rand cfg%0d a=%h b=%h", g, ra, rb));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpmult_radix_sat.md
FPMULT_RADIX_SAT -- requirements
Module: fpmult_radix_sat

Interface
REQ-001 Parameter N, default 32: operand and result bit width.
REQ-002 Parameter D, default 16: number of fractional bits; 0 <= D < N.
REQ-003 Parameter SIGN, default 1: 1 means two's-complement operands, 0 means unsigned.
REQ-004 Parameter K, default 2: multiplier bits retired per CALC cycle; N % K == 0 is required, and elaboration SHALL fail otherwise.
REQ-005 Parameter SAT, default 1: 1 means saturate on overflow, 0 means wrap.
REQ-006 Parameter RND, default 0: 1 means round half-up at bit D-1, 0 means truncate toward negative infinity.
REQ-007 clk  input  1  single clock; all state changes on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 recv_val  input  1  operand pair a, b is valid.
REQ-010 recv_rdy  output  1  block can accept operands.
REQ-011 a  input  N  multiplicand, fixed point with D fractional bits.
REQ-012 b  input  N  multiplier, fixed point with D fractional bits.
REQ-013 send_val  output  1  result c is valid.
REQ-014 send_rdy  input  1  consumer accepts the result.
REQ-015 c  output  N  result (a*b) >> D, after rounding and saturation.
REQ-016 ovf  output  1  the unsaturated result did not fit in N bits; qualified by send_val.

Function
REQ-017 FSM states: IDLE, CALC, DONE.
- IDLE -> CALC on recv_val.
- CALC -> DONE after exactly N/K CALC cycles.
- DONE -> IDLE on send_rdy.
REQ-018 recv_rdy SHALL be 1 only in IDLE. send_val SHALL be 1 only in DONE.
REQ-019 a and b SHALL be captured on the IDLE-state recv_val cycle (handshake cycle t). Later changes on a and b SHALL have no effect on the result.
REQ-020 Latency: send_val SHALL first assert in cycle t+N/K+1.
REQ-021 Throughput: the next accept is no earlier than one cycle after the DONE handshake, because DONE->IDLE takes one cycle.
REQ-022 Product arithmetic:
- The full 2N-bit product SHALL be formed, signed if SIGN=1, unsigned if SIGN=0.
- K bits of b SHALL be consumed per CALC cycle, LSB first.
- For SIGN=1, the final partial product (b MSB weight) SHALL be subtracted.
REQ-023 Rounding: RND=1 adds 2^(D-1) to the 2N-bit product before the arithmetic right shift by D; RND=0 applies the shift only.
REQ-024 Overflow: ovf=1 when the shifted value is outside the N-bit range, signed or unsigned according to SIGN.
REQ-025 Saturation with SAT=1 and ovf=1: c SHALL be the max or min representable value, following the sign of the true product.
REQ-026 Wrap with SAT=0: c SHALL be the low N bits of the shifted value; ovf is still reported.
REQ-027 c and ovf SHALL remain stable throughout DONE, regardless of send_rdy stall length.
REQ-028 c and ovf are don't-care outside DONE, but SHALL contain no X after reset.
REQ-029 recv_val asserted in CALC or DONE SHALL be ignored and SHALL NOT corrupt the in-flight operation.
REQ-030 Zero operand: result c=0, ovf=0, same latency as any other operand pair (no early exit).

Reset
REQ-031 reset=1 SHALL, on the next edge, set state to IDLE, the iteration counter to 0, and all accumulator and operand registers to 0.
REQ-032 Output values while in reset: recv_rdy=1, send_val=0, c=0, ovf=0.
REQ-033 reset in CALC or DONE SHALL abort the operation; no send_val SHALL appear for the aborted pair.
REQ-034 reset takes priority over recv_val and send_rdy in the same cycle.

Verification (N=32, D=16, K=2, SIGN=1 unless stated)
REQ-035 Basic: a=0x00018000, b=0x00020000 (1.5*2.0), send_rdy=1 -> c=0x00030000, ovf=0, send_val at t+17.
REQ-036 Signed: a=0xFFFF8000, b=0x00040000 (-0.5*4) -> c=0xFFFE0000, ovf=0.
REQ-037 Overflow: a=0x7FFF0000, b=0x00020000.
- SAT=1 -> c=0x7FFFFFFF, ovf=1.
- SAT=0 -> c=0xFFFE0000, ovf=1.
REQ-038 Rounding: a=0x00000001, b=0x00008000.
- RND=0 -> c=0x00000000.
- RND=1 -> c=0x00000001.
REQ-039 Backpressure and handshake:
- Hold send_rdy=0 for 5 cycles in DONE -> c and send_val stable, recv_rdy=0.
- recv_val pulsed mid-CALC with other operands -> ignored.
REQ-040 Reset mid-CALC at cycle t+5 -> next cycle recv_rdy=1, send_val=0.
- A following pair a=0x00010000, b=0x00010000 -> c=0x00010000.
- Also sweep K in {1,4,32} and SIGN=0 against a reference model using random operands.
